asteroid_spawner: RTL and testbench
===================================

// Module: asteroid_spawner
// PURPOSE
// - Consumer of the 32-bit pseudo-random word from the LFSR generator; owns the asteroid field.
// - One game_clk tick = one frame. Periodically spawns an asteroid at a random x with a random fall speed.
// - Advances all live asteroids each frame and retires those leaving the screen bottom.
// - Feeds the renderer (positions/active mask) and the score logic (dodged count).
// PARAMETERS
// - NUM_AST       8    asteroid slots
// - SCREEN_W      640  visible width, pixels
// - SCREEN_H      480  visible height, pixels
// - AST_SIZE      32   asteroid edge, pixels; x range 0..SCREEN_W-AST_SIZE-1
// - SPAWN_PERIOD  30   frames between spawn attempts (>=1)
// PORTS
// - game_clk       in   1            frame clock
// - rst            in   1            synchronous, active-high reset
// - game_state_w   in   2            00 IDLE, 01 OPENING_SCREEN, 10 GAME_RUNNING, 11 GAME_OVER
// - random_number  in   32           LFSR output, sampled on the same game_clk edge
// - ast_active     out  NUM_AST      bit i = slot i live
// - ast_x          out  NUM_AST*10   slot i x at [10*i +: 10]
// - ast_y          out  NUM_AST*10   slot i y (top edge) at [10*i +: 10]
// - spawn_pulse    out  1            1-tick high on the frame a spawn was written
// - dodged_count   out  16           asteroids retired off-screen, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset: all outputs 0; all slot speeds 0; spawn timer = SPAWN_PERIOD-1; prev_state = IDLE.
// - IDLE / OPENING_SCREEN: every tick, clear all slots, dodged_count and spawn_pulse; timer = SPAWN_PERIOD-1.
// - Entry to GAME_RUNNING (prev_state != 10, state == 10): same clear as above on that tick. No move, no spawn.
// - GAME_RUNNING, each tick, for every live slot i:
//     next_y = y + speed (11-bit).
//     If next_y >= SCREEN_H: active <= 0; counts toward dodged_count.
//     Else: y <= next_y.
//   dodged_count += number retired this tick, saturating.
// - Spawn timer, GAME_RUNNING only: decrements each tick. At 0 it reloads SPAWN_PERIOD-1 and attempts a spawn.
// - Spawn target: lowest-index slot with active==0 before this tick's retirements.
//   A slot freed this tick is not reusable until the next tick.
// - Spawn write:
//     x_raw = random_number[9:0]
//     x = (x_raw >= SCREEN_W-AST_SIZE) ? x_raw-(SCREEN_W-AST_SIZE) : x_raw   (one subtract is sufficient)
//     speed = {1'b0, random_number[17:16]} + 1, range 1..4
//     y = 0; active = 1; spawn_pulse = 1.
// - No free slot: spawn dropped, spawn_pulse=0, timer still reloads.
// - Spawned asteroid does not move on its spawn tick.
// - GAME_OVER: all slot state, timer and dodged_count hold. spawn_pulse=0.
// - GAME_OVER -> GAME_RUNNING is an entry, so it clears.
// - rst mid-game overrides everything on that edge.
// - Latency: outputs registered; a state change becomes visible one tick after the edge that samples it.
// STRUCTURE
// - Shared include game_defs.vh:
//   - state encodings IDLE/OPENING_SCREEN/GAME_RUNNING/GAME_OVER
//   - SCREEN_W/SCREEN_H
//   - The LFSR generator uses the same definitions.
// - Sub-module asteroid_slot (one per slot, generate loop):
//   - holds active/x/y/speed
//   - inputs: clear, step, load (x, speed)
//   - output: retire pulse
// - Top level holds:
//   - spawn timer
//   - free-slot priority encoder
//   - retire popcount
//   - dodged_count
//   - prev_state register
// TESTING
// - Reset, then state=10 held 1 tick -> all outputs 0.
//   First spawn_pulse 30 ticks after entry (SPAWN_PERIOD=30), into slot 0.
// - random_number=32'h0003_0100 at spawn tick -> slot0 x=256, speed=4, y=0.
//   120 ticks later: active0=0, dodged_count=1.
// - random_number[9:0]=1000 -> x=392; [9:0]=607 -> x=607; [9:0]=608 -> x=0.
// - random_number[17:16]=0 (speed 1), 8 spawns fill all slots.
//   9th spawn tick: spawn_pulse=0, ast_active stays 8'hFF, next attempt 30 ticks later.
// - Slot 0 retires on the same tick a spawn fires with slots 1..7 busy -> spawn dropped.
//   Next attempt succeeds into slot 0.
// - State 10 -> 11 for 50 ticks: ast_y/ast_x/dodged_count constant.
//   Then 11 -> 10: all cleared on entry tick.
//   Forced dodged_count 16'hFFFF plus a retire: stays 16'hFFFF.

Source files
------------

// File: rtl/asteroid_spawner_pkg.sv
// Shared game definitions: state encodings, screen geometry and spawn x wrapping.
package asteroid_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_OPENING   = 2'b01,
        ST_RUNNING   = 2'b10,
        ST_GAME_OVER = 2'b11
    } game_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int AST_SIZE = 32;
    localparam int X_SPAN   = SCREEN_W - AST_SIZE;

    // Fold a raw 10-bit random value into 0..X_SPAN-1; 1023 - X_SPAN < X_SPAN so one subtract is enough
    function automatic logic [9:0] wrapSpawnX(input logic [9:0] xRaw);
        logic [9:0] result;
        result = xRaw;
        if (xRaw >= 10'(X_SPAN)) begin
            result = xRaw - 10'(X_SPAN);
        end
        return result;
    endfunction

endpackage

// File: rtl/asteroid_spawner_slot.sv
// One asteroid slot: position, fall speed and live flag, with a retire pulse when it leaves the screen.
module asteroid_spawner_slot
    import asteroid_spawner_pkg::*;
(
    input  logic       game_clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic       load_i,
    input  logic [9:0] loadX_i,
    input  logic [2:0] loadSpeed_i,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       retire_o
);

    logic        active_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [2:0]  speed_q;
    logic [10:0] nextY;

    assign nextY    = {1'b0, y_q} + {8'd0, speed_q};
    assign retire_o = active_q && step_i && (nextY >= 11'(SCREEN_H));
    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;

    // Clear wins, then a fresh spawn, otherwise a live asteroid falls or retires off the bottom
    always_ff @(posedge game_clk) begin
        if (rst || clear_i) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            speed_q  <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            x_q      <= loadX_i;
            y_q      <= '0;
            speed_q  <= loadSpeed_i;
        end else if (step_i && active_q) begin
            if (retire_o) begin
                active_q <= 1'b0;
            end else begin
                y_q <= nextY[9:0];
            end
        end
    end

endmodule

// File: rtl/asteroid_spawner.sv
// Asteroid field owner: spawn timer, free-slot pick, per-frame motion and the dodged counter.
module asteroid_spawner
    import asteroid_spawner_pkg::*;
#(
    parameter int NUM_AST      = 8,
    parameter int SPAWN_PERIOD = 30
) (
    input  logic                  game_clk,
    input  logic                  rst,
    input  logic [1:0]            game_state_w,
    input  logic [31:0]           random_number,
    output logic [NUM_AST-1:0]    ast_active,
    output logic [NUM_AST*10-1:0] ast_x,
    output logic [NUM_AST*10-1:0] ast_y,
    output logic                  spawn_pulse,
    output logic [15:0]           dodged_count
);

    localparam int TIMER_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int CNT_W   = $clog2(NUM_AST + 1);
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SPAWN_PERIOD - 1);

    game_state_e        state;
    game_state_e        prevState_q;
    logic [TIMER_W-1:0] spawnTimer_q;
    logic [TIMER_W-1:0] spawnTimer_d;
    logic [15:0]        dodgedCount_q;
    logic [15:0]        dodgedCount_d;
    logic               spawnPulse_q;

    logic               running;
    logic               entry;
    logic               clearAll;
    logic               stepAll;
    logic               spawnAttempt;
    logic               freeFound;
    logic [NUM_AST-1:0] freeOneHot;
    logic [NUM_AST-1:0] loadVec;
    logic [NUM_AST-1:0] retireVec;
    logic [CNT_W-1:0]   retireCount;
    logic [16:0]        dodgedSum;
    logic [9:0]         spawnX;
    logic [2:0]         spawnSpeed;
    logic               unusedRandomBits;

    assign state    = game_state_e'(game_state_w);
    assign running  = (state == ST_RUNNING);
    assign entry    = running && (prevState_q != ST_RUNNING);
    assign clearAll = (state == ST_IDLE) || (state == ST_OPENING) || entry;
    assign stepAll  = running && !entry;
    assign spawnAttempt = stepAll && (spawnTimer_q == '0);
    assign loadVec  = freeOneHot & {NUM_AST{spawnAttempt}};

    assign spawnX     = wrapSpawnX(random_number[9:0]);
    assign spawnSpeed = {1'b0, random_number[17:16]} + 3'd1;
    assign unusedRandomBits = ^{random_number[31:18], random_number[15:10]};

    // Lowest-index free slot, judged on the live flags before this frame's retirements
    always_comb begin
        freeFound  = 1'b0;
        freeOneHot = '0;
        for (int i = 0; i < NUM_AST; i++) begin
            if (!ast_active[i] && !freeFound) begin
                freeFound     = 1'b1;
                freeOneHot[i] = 1'b1;
            end
        end
    end

    // Count asteroids leaving the screen this frame and fold them into the saturating total
    always_comb begin
        retireCount = '0;
        for (int i = 0; i < NUM_AST; i++) begin
            retireCount = retireCount + CNT_W'(retireVec[i]);
        end
        dodgedSum     = {1'b0, dodgedCount_q} + 17'(retireCount);
        dodgedCount_d = dodgedSum[16] ? 16'hFFFF : dodgedSum[15:0];
        spawnTimer_d  = spawnAttempt ? RELOAD : (spawnTimer_q - TIMER_W'(1));
    end

    // Frame-level bookkeeping: clears in menus and on entry, advances while running, freezes on game over
    always_ff @(posedge game_clk) begin
        if (rst) begin
            prevState_q   <= ST_IDLE;
            spawnTimer_q  <= RELOAD;
            dodgedCount_q <= '0;
            spawnPulse_q  <= 1'b0;
        end else begin
            prevState_q <= state;
            if (clearAll) begin
                spawnTimer_q  <= RELOAD;
                dodgedCount_q <= '0;
                spawnPulse_q  <= 1'b0;
            end else if (stepAll) begin
                spawnTimer_q  <= spawnTimer_d;
                dodgedCount_q <= dodgedCount_d;
                spawnPulse_q  <= spawnAttempt && freeFound;
            end else begin
                spawnPulse_q <= 1'b0;
            end
        end
    end

    assign spawn_pulse  = spawnPulse_q;
    assign dodged_count = dodgedCount_q;

    for (genvar i = 0; i < NUM_AST; i++) begin : gen_slot
        asteroid_spawner_slot u_slot (
            .game_clk    (game_clk),
            .rst         (rst),
            .clear_i     (clearAll),
            .step_i      (stepAll),
            .load_i      (loadVec[i]),
            .loadX_i     (spawnX),
            .loadSpeed_i (spawnSpeed),
            .active_o    (ast_active[i]),
            .x_o         (ast_x[10*i +: 10]),
            .y_o         (ast_y[10*i +: 10]),
            .retire_o    (retireVec[i])
        );
    end

endmodule

// File: tb/tb_asteroid_spawner.sv
// Self-checking bench for asteroid_spawner: directed scenarios plus random play against a frame-level model.
module tb_asteroid_spawner;

    localparam int NUM_AST = 8;
    localparam int PERIOD  = 30;
    localparam int SCR_H   = 480;
    localparam int XSPAN   = 608;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OPEN = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_OVER = 2'b11;

    logic                  game_clk = 1'b0;
    logic                  rst;
    logic [1:0]            game_state_w;
    logic [31:0]           random_number;
    logic [NUM_AST-1:0]    ast_active;
    logic [NUM_AST*10-1:0] ast_x;
    logic [NUM_AST*10-1:0] ast_y;
    logic                  spawn_pulse;
    logic [15:0]           dodged_count;

    int    compareCount  = 0;
    int    mismatchCount = 0;
    string phaseName     = "reset";

    // Frame-level model of the asteroid field
    bit         mActive[NUM_AST];
    int         mX[NUM_AST];
    int         mY[NUM_AST];
    int         mSpeed[NUM_AST];
    int         mTimer;
    int         mDodged;
    bit         mPulse;
    logic [1:0] mPrev;

    asteroid_spawner dut (
        .game_clk      (game_clk),
        .rst           (rst),
        .game_state_w  (game_state_w),
        .random_number (random_number),
        .ast_active    (ast_active),
        .ast_x         (ast_x),
        .ast_y         (ast_y),
        .spawn_pulse   (spawn_pulse),
        .dodged_count  (dodged_count)
    );

    // Frame clock
    always #5 game_clk = ~game_clk;

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s/%s at %0t: observed %h expected %h", phaseName, tag, $time, observed, expected);
        end
    endtask

    task automatic modelClearField();
        for (int i = 0; i < NUM_AST; i++) begin
            mActive[i] = 1'b0;
            mX[i] = 0;
            mY[i] = 0;
            mSpeed[i] = 0;
        end
        mTimer  = PERIOD - 1;
        mDodged = 0;
        mPulse  = 1'b0;
    endtask

    task automatic modelStep(input logic r, input logic [1:0] st, input logic [31:0] rn);
        bit wasActive[NUM_AST];
        int retired;
        int xr;
        int target;
        if (r) begin
            modelClearField();
            mPrev = S_IDLE;
        end else begin
            if (st == S_IDLE || st == S_OPEN || (st == S_RUN && mPrev != S_RUN)) begin
                modelClearField();
            end else if (st == S_RUN) begin
                for (int i = 0; i < NUM_AST; i++) wasActive[i] = mActive[i];
                retired = 0;
                for (int i = 0; i < NUM_AST; i++) begin
                    if (mActive[i]) begin
                        if (mY[i] + mSpeed[i] >= SCR_H) begin
                            mActive[i] = 1'b0;
                            retired++;
                        end else begin
                            mY[i] = mY[i] + mSpeed[i];
                        end
                    end
                end
                mDodged = (mDodged + retired > 65535) ? 65535 : mDodged + retired;
                mPulse = 1'b0;
                if (mTimer == 0) begin
                    mTimer = PERIOD - 1;
                    target = -1;
                    for (int i = NUM_AST - 1; i >= 0; i--) if (!wasActive[i]) target = i;
                    if (target >= 0) begin
                        xr = int'(rn[9:0]);
                        mX[target]      = (xr >= XSPAN) ? xr - XSPAN : xr;
                        mY[target]      = 0;
                        mSpeed[target]  = int'(rn[17:16]) + 1;
                        mActive[target] = 1'b1;
                        mPulse = 1'b1;
                    end
                end else begin
                    mTimer--;
                end
            end else begin
                mPulse = 1'b0;
            end
            mPrev = st;
        end
    endtask

    task automatic compareAll();
        logic [79:0] eX;
        logic [79:0] eY;
        logic [7:0]  eA;
        eX = '0;
        eY = '0;
        eA = '0;
        for (int i = 0; i < NUM_AST; i++) begin
            eA[i] = mActive[i];
            eX[10*i +: 10] = 10'(mX[i]);
            eY[10*i +: 10] = 10'(mY[i]);
        end
        checkOutput("active", 80'(ast_active), 80'(eA));
        checkOutput("x", ast_x, eX);
        checkOutput("y", ast_y, eY);
        checkOutput("pulse", 80'(spawn_pulse), 80'(mPulse));
        checkOutput("dodged", 80'(dodged_count), 80'(mDodged));
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] st, input logic [31:0] rn);
        rst = r;
        game_state_w = st;
        random_number = rn;
        @(posedge game_clk);
        modelStep(r, st, rn);
        #1;
        compareAll();
    endtask

    function automatic logic [31:0] speedOneWord();
        logic [31:0] w;
        w = $urandom;
        w[17:16] = 2'b00;
        return w;
    endfunction

    initial begin
        int xRawList[3];
        int xExpList[3];
        int segLen;
        int pick;
        logic [1:0] segState;
        logic [31:0] rn;

        xRawList = '{1000, 607, 608};
        xExpList = '{392, 607, 0};
        rst = 1'b1;
        game_state_w = S_IDLE;
        random_number = '0;
        mPrev = S_IDLE;
        modelClearField();

        // Reset
        applyStimulus(1'b1, S_IDLE, 32'h0);
        applyStimulus(1'b1, S_RUN, 32'hFFFF_FFFF);
        checkOutput("rst_active", 80'(ast_active), 80'(0));
        checkOutput("rst_dodged", 80'(dodged_count), 80'(0));
        applyStimulus(1'b0, S_IDLE, 32'h0);

        // Entry, first spawn at frame 30, retirement 120 frames later
        phaseName = "first_spawn";
        applyStimulus(1'b0, S_RUN, 32'h0003_0100);
        checkOutput("entry_active", 80'(ast_active), 80'(0));
        for (int t = 1; t <= 160; t++) begin
            applyStimulus(1'b0, S_RUN, 32'h0003_0100);
            if (t == 29) checkOutput("no_early_pulse", 80'(spawn_pulse), 80'(0));
            if (t == 30) begin
                checkOutput("pulse30", 80'(spawn_pulse), 80'(1));
                checkOutput("x0", 80'(ast_x[9:0]), 80'(256));
                checkOutput("y0", 80'(ast_y[9:0]), 80'(0));
            end
            if (t == 150) begin
                checkOutput("retired0", 80'(ast_active[0]), 80'(0));
                checkOutput("dodged1", 80'(dodged_count), 80'(1));
            end
        end

        // Spawn x wrapping at the edges of the range
        phaseName = "x_wrap";
        applyStimulus(1'b0, S_OPEN, $urandom);
        applyStimulus(1'b0, S_RUN, $urandom);
        for (int k = 0; k < 3; k++) begin
            for (int t = 1; t <= PERIOD; t++) begin
                rn = $urandom;
                if (t == PERIOD) rn[9:0] = 10'(xRawList[k]);
                applyStimulus(1'b0, S_RUN, rn);
            end
            checkOutput("xwrap", 80'(ast_x[10*k +: 10]), 80'(xExpList[k]));
        end

        // Speed-1 asteroids fill every slot; drop on full field and on same-frame retirement
        phaseName = "fill";
        applyStimulus(1'b0, S_IDLE, $urandom);
        applyStimulus(1'b0, S_RUN, speedOneWord());
        for (int t = 1; t <= 545; t++) begin
            applyStimulus(1'b0, S_RUN, speedOneWord());
            if (t == 240) checkOutput("full", 80'(ast_active), 80'(8'hFF));
            if (t == 270) begin
                checkOutput("drop_pulse", 80'(spawn_pulse), 80'(0));
                checkOutput("drop_active", 80'(ast_active), 80'(8'hFF));
            end
            if (t == 510) begin
                checkOutput("freed_drop_pulse", 80'(spawn_pulse), 80'(0));
                checkOutput("freed_drop_active", 80'(ast_active), 80'(8'hFE));
            end
            if (t == 540) begin
                checkOutput("reuse_pulse", 80'(spawn_pulse), 80'(1));
                checkOutput("reuse_active0", 80'(ast_active[0]), 80'(1));
            end
        end

        // Game over freezes the field, re-entry clears it
        phaseName = "game_over";
        for (int t = 0; t < 50; t++) applyStimulus(1'b0, S_OVER, $urandom);
        applyStimulus(1'b0, S_RUN, $urandom);
        checkOutput("reentry_active", 80'(ast_active), 80'(0));
        checkOutput("reentry_dodged", 80'(dodged_count), 80'(0));

        // Random play across all states
        phaseName = "random";
        for (int seg = 0; seg < 14; seg++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 6) begin
                segState = S_RUN;
                segLen = int'($urandom_range(20, 150));
            end else if (pick < 9) begin
                segState = S_OVER;
                segLen = int'($urandom_range(3, 30));
            end else begin
                segState = ($urandom_range(0, 1) == 0) ? S_IDLE : S_OPEN;
                segLen = int'($urandom_range(1, 3));
            end
            for (int t = 0; t < segLen; t++) begin
                rn = $urandom;
                case ($urandom_range(0, 3))
                    0: rn[9:0] = 10'd1000;
                    1: rn[9:0] = 10'd607;
                    2: rn[9:0] = 10'd608;
                    default: rn[9:0] = rn[9:0];
                endcase
                applyStimulus(1'b0, segState, rn);
            end
        end

        // Saturation of the dodged counter
        phaseName = "saturate";
        applyStimulus(1'b0, S_IDLE, 32'h0);
        applyStimulus(1'b0, S_RUN, 32'h0003_0100);
        for (int t = 1; t < 150; t++) applyStimulus(1'b0, S_RUN, 32'h0003_0100);
        force dut.dodgedCount_q = 16'hFFFF;
        #1;
        release dut.dodgedCount_q;
        mDodged = 65535;
        for (int t = 150; t <= 185; t++) begin
            applyStimulus(1'b0, S_RUN, 32'h0003_0100);
            if (t == 150) checkOutput("sat150", 80'(dodged_count), 80'(16'hFFFF));
            if (t == 180) checkOutput("sat180", 80'(dodged_count), 80'(16'hFFFF));
        end

        // Reset in the middle of a game
        phaseName = "mid_reset";
        applyStimulus(1'b1, S_RUN, $urandom);
        checkOutput("mid_rst_active", 80'(ast_active), 80'(0));
        for (int t = 0; t < 40; t++) applyStimulus(1'b0, S_RUN, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
